// File: rtl/portal_pkg.sv
// Shared portal message definitions: widths, field offsets, message layout and the
// helper that picks one 32-bit word out of a 96-bit message.
package portal_pkg;

  localparam int PORTAL_MSG_W     = 96;
  localparam int PORTAL_WORD_W    = 32;
  localparam int PORTAL_MSG_WORDS = 3;
  localparam int PORTAL_IDX_W     = 2;

  localparam int PORTAL_HDR_LSB  = 0;
  localparam int PORTAL_ARG0_LSB = 32;
  localparam int PORTAL_ARG1_LSB = 64;

  typedef struct packed {
    logic [PORTAL_WORD_W-1:0] arg1;
    logic [PORTAL_WORD_W-1:0] arg0;
    logic [PORTAL_WORD_W-1:0] header;
  } portal_msg_t;

  // Word order on the wire: header first, then arg0, then arg1.
  typedef enum logic [PORTAL_IDX_W-1:0] {
    WORD_HDR  = 2'd0,
    WORD_ARG0 = 2'd1,
    WORD_ARG1 = 2'd2
  } portal_word_e;

  function automatic logic [PORTAL_WORD_W-1:0] portal_word(input portal_msg_t m,
                                                           input portal_word_e idx);
    case (idx)
      WORD_ARG0: return m.arg0;
      WORD_ARG1: return m.arg1;
      default:   return m.header;
    endcase
  endfunction

endpackage

// File: rtl/portal_msg_fifo.sv
// DEPTH-entry message FIFO with naturally wrapping pointers and an explicit occupancy
// counter, so full and empty are distinguishable without a spare entry.
module portal_msg_fifo
  import portal_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  portal_msg_t push_data,
  input  logic        pop,
  output portal_msg_t head,
  output logic        full,
  output logic        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   OCC_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   OCC_MAX = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occupancy;
  portal_msg_t      mem [DEPTH];

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order across always_ff blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_ONE;
        2'b01:   occupancy <= occupancy - OCC_ONE;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy alone decides which entries are
  // valid, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (occupancy == OCC_MAX);
  assign empty = (occupancy == '0);

endmodule

// File: rtl/portal_msg_serializer.sv
// Buffers 96-bit portal messages and emits each as three 32-bit words with a
// last-word flag, honouring consumer backpressure and counting delivered messages.
module portal_msg_serializer
  import portal_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WORDS = PORTAL_MSG_WORDS,
  parameter int CNT_W = 16
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     pipe_enq__ENA,
  input  logic [PORTAL_MSG_W-1:0]  pipe_enq_v,
  output logic                     pipe_enq__RDY,
  output logic                     word_enq__ENA,
  output logic [PORTAL_WORD_W-1:0] word_enq_v,
  output logic                     word_enq_last,
  input  logic                     word_enq__RDY,
  output logic [CNT_W-1:0]         msg_count
);

  localparam portal_word_e LAST_IDX = portal_word_e'(PORTAL_IDX_W'(WORDS - 1));

  portal_msg_t  head;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic         beat;
  portal_word_e word_idx;
  portal_word_e word_idx_nxt;

  portal_msg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (CLK),
    .rst       (nRST),
    .push      (push),
    .push_data (pipe_enq_v),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // No bypass: a full FIFO stays unready even while its head is being popped.
  assign pipe_enq__RDY = !nRST && !full;
  assign push          = pipe_enq__ENA && pipe_enq__RDY;
  assign beat          = !nRST && !empty && word_enq__RDY;
  assign word_enq__ENA = beat;

  always_ff @(posedge CLK) begin
    if (nRST) word_idx <= WORD_HDR;
    else      word_idx <= word_idx_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    word_idx_nxt  = word_idx;
    pop           = 1'b0;
    word_enq_v    = '0;
    word_enq_last = 1'b0;
    if (beat) begin
      word_enq_v    = portal_word(head, word_idx);
      word_enq_last = (word_idx == LAST_IDX);
      if (word_idx == LAST_IDX) begin
        word_idx_nxt = WORD_HDR;
        pop          = 1'b1;
      end else begin
        word_idx_nxt = portal_word_e'(word_idx + PORTAL_IDX_W'(1));
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST)     msg_count <= '0;
    else if (pop) msg_count <= msg_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_portal_msg_serializer.sv
// Directed bench for portal_msg_serializer: a vector table for the main flows plus a
// hand-written counter-wrap sequence on a narrow-counter second instance.
module tb_portal_msg_serializer;

  logic        clk;
  logic        nrst;
  logic        enq_ena;
  logic [95:0] enq_v;
  logic        enq_rdy;
  logic        w_ena;
  logic [31:0] w_v;
  logic        w_last;
  logic        w_rdy;
  logic [15:0] msg_count;

  logic        s_enq_rdy;
  logic        s_w_ena;
  logic [31:0] s_w_v;
  logic        s_w_last;
  logic [1:0]  s_count;

  int checks = 0;
  int errors = 0;
  int viol_seen = 0;
  logic viol_ok = 1'b0;

  portal_msg_serializer #(.DEPTH(2), .WORDS(3), .CNT_W(16)) dut (
    .CLK           (clk),
    .nRST          (nrst),
    .pipe_enq__ENA (enq_ena),
    .pipe_enq_v    (enq_v),
    .pipe_enq__RDY (enq_rdy),
    .word_enq__ENA (w_ena),
    .word_enq_v    (w_v),
    .word_enq_last (w_last),
    .word_enq__RDY (w_rdy),
    .msg_count     (msg_count)
  );

  // Narrow counter instance sharing all stimulus, used to observe modulo wrap.
  portal_msg_serializer #(.DEPTH(2), .WORDS(3), .CNT_W(2)) dut_small (
    .CLK           (clk),
    .nRST          (nrst),
    .pipe_enq__ENA (enq_ena),
    .pipe_enq_v    (enq_v),
    .pipe_enq__RDY (s_enq_rdy),
    .word_enq__ENA (s_w_ena),
    .word_enq_v    (s_w_v),
    .word_enq_last (s_w_last),
    .word_enq__RDY (w_rdy),
    .msg_count     (s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol monitor: an enqueue strobe while unready is only tolerated where expected.
  always @(posedge clk) begin
    if (enq_ena && !enq_rdy) begin
      if (viol_ok) viol_seen++;
      else begin
        errors++;
        $display("FAIL protocol: pipe enq ENA=1 while RDY=0 at %0t", $time);
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        ena;
    logic [95:0] v;
    logic        wrdy;
    logic        x_prdy;
    logic        x_wena;
    logic [31:0] x_wv;
    logic        x_last;
    logic [15:0] x_cnt;
  } vec_t;

  vec_t vq[$];

  localparam logic [95:0] MA  = {32'h3333_3333, 32'h2222_2222, 32'h0000_0001};
  localparam logic [95:0] MA2 = {32'hAAAA_0002, 32'hAAAA_0001, 32'h0000_000A};
  localparam logic [95:0] MB  = {32'hBBBB_0002, 32'hBBBB_0001, 32'h0000_000B};
  localparam logic [95:0] MC  = {32'hCCCC_0002, 32'hCCCC_0001, 32'h0000_000C};
  localparam logic [95:0] MD  = {32'hDDDD_0002, 32'hDDDD_0001, 32'h0000_000D};
  localparam logic [95:0] ME  = {32'hEEEE_0002, 32'hEEEE_0001, 32'h0000_000E};
  localparam logic [95:0] MF  = {32'hFFFF_0002, 32'hFFFF_0001, 32'h0000_000F};
  localparam logic [95:0] MG  = {32'h7777_0002, 32'h7777_0001, 32'h0000_0007};

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic ena, input logic [95:0] v, input logic wrdy,
                     input logic x_prdy, input logic x_wena, input logic [31:0] x_wv,
                     input logic x_last, input logic [15:0] x_cnt);
    vec_t t;
    t.rst = rst; t.ena = ena; t.v = v; t.wrdy = wrdy;
    t.x_prdy = x_prdy; t.x_wena = x_wena; t.x_wv = x_wv; t.x_last = x_last; t.x_cnt = x_cnt;
    vq.push_back(t);
  endtask

  // Drive one cycle's inputs after the falling edge, then compare outputs mid-cycle.
  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    nrst    = t.rst;
    enq_ena = t.ena;
    enq_v   = t.v;
    w_rdy   = t.wrdy;
    viol_ok = t.ena && !t.x_prdy;
    #1;
    check({tag, "_prdy"}, 96'(enq_rdy), 96'(t.x_prdy));
    check({tag, "_wena"}, 96'(w_ena), 96'(t.x_wena));
    check({tag, "_wv"}, 96'(w_v), 96'(t.x_wv));
    check({tag, "_last"}, 96'(w_last), 96'(t.x_last));
    check({tag, "_cnt"}, 96'(msg_count), 96'(t.x_cnt));
    check({tag, "_scnt"}, 96'(s_count), 96'(t.x_cnt[1:0]));
  endtask

  initial begin
    vec_t        t;
    logic [95:0] m;
    logic [15:0] exp_cnt;

    nrst = 1'b1; enq_ena = 1'b0; enq_v = '0; w_rdy = 1'b0;
    repeat (2) @(posedge clk);

    //  rst ena  v   wrdy prdy wena wv             last cnt
    // Reset state, then a single message.
    add(1, 0, '0,  1, 0, 0, 32'h0,          0, 0);
    add(0, 1, MA,  1, 1, 0, 32'h0,          0, 0);
    add(0, 0, '0,  1, 1, 1, 32'h0000_0001,  0, 0);
    add(0, 0, '0,  1, 1, 1, 32'h2222_2222,  0, 0);
    add(0, 0, '0,  1, 1, 1, 32'h3333_3333,  1, 0);
    add(0, 0, '0,  1, 1, 0, 32'h0,          0, 1);
    // Backpressure 1,0,0,1,1.
    add(0, 1, MA,  1, 1, 0, 32'h0,          0, 1);
    add(0, 0, '0,  1, 1, 1, 32'h0000_0001,  0, 1);
    add(0, 0, '0,  0, 1, 0, 32'h0,          0, 1);
    add(0, 0, '0,  0, 1, 0, 32'h0,          0, 1);
    add(0, 0, '0,  1, 1, 1, 32'h2222_2222,  0, 1);
    add(0, 0, '0,  1, 1, 1, 32'h3333_3333,  1, 1);
    add(0, 0, '0,  1, 1, 0, 32'h0,          0, 2);
    // Full FIFO: A and B buffered while stalled, C ignored.
    add(0, 1, MA2, 0, 1, 0, 32'h0,          0, 2);
    add(0, 1, MB,  0, 1, 0, 32'h0,          0, 2);
    add(0, 1, MC,  0, 0, 0, 32'h0,          0, 2);
    add(0, 0, '0,  1, 0, 1, 32'h0000_000A,  0, 2);
    add(0, 0, '0,  1, 0, 1, 32'hAAAA_0001,  0, 2);
    add(0, 0, '0,  1, 0, 1, 32'hAAAA_0002,  1, 2);
    add(0, 0, '0,  1, 1, 1, 32'h0000_000B,  0, 3);
    add(0, 0, '0,  1, 1, 1, 32'hBBBB_0001,  0, 3);
    add(0, 0, '0,  1, 1, 1, 32'hBBBB_0002,  1, 3);
    add(0, 0, '0,  1, 1, 0, 32'h0,          0, 4);
    // Enqueue coincides with the last word of the only buffered message.
    add(0, 1, MD,  1, 1, 0, 32'h0,          0, 4);
    add(0, 0, '0,  1, 1, 1, 32'h0000_000D,  0, 4);
    add(0, 0, '0,  1, 1, 1, 32'hDDDD_0001,  0, 4);
    add(0, 1, ME,  1, 1, 1, 32'hDDDD_0002,  1, 4);
    add(0, 0, '0,  1, 1, 1, 32'h0000_000E,  0, 5);
    add(0, 0, '0,  1, 1, 1, 32'hEEEE_0001,  0, 5);
    add(0, 0, '0,  1, 1, 1, 32'hEEEE_0002,  1, 5);
    add(0, 0, '0,  1, 1, 0, 32'h0,          0, 6);
    // Reset after word 1 of a message.
    add(0, 1, MF,  1, 1, 0, 32'h0,          0, 6);
    add(0, 0, '0,  1, 1, 1, 32'h0000_000F,  0, 6);
    add(0, 0, '0,  1, 1, 1, 32'hFFFF_0001,  0, 6);
    add(1, 0, '0,  1, 0, 0, 32'h0,          0, 6);
    add(0, 1, MG,  1, 1, 0, 32'h0,          0, 0);
    add(0, 0, '0,  1, 1, 1, 32'h0000_0007,  0, 0);
    add(0, 0, '0,  1, 1, 1, 32'h7777_0001,  0, 0);
    add(0, 0, '0,  1, 1, 1, 32'h7777_0002,  1, 0);
    add(0, 0, '0,  1, 1, 0, 32'h0,          0, 1);

    for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("v%0d", i));

    // Three more messages take the narrow counter from 1 through 3 and wrap to 0.
    exp_cnt = 16'd1;
    for (int k = 0; k < 3; k++) begin
      m = {32'h5000_0002 + 32'(k << 8), 32'h5000_0001 + 32'(k << 8), 32'h5000_0000 + 32'(k)};
      t = '{1'b0, 1'b1, m, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, exp_cnt};
      apply(t, $sformatf("wrap%0d_enq", k));
      t = '{1'b0, 1'b0, 96'h0, 1'b1, 1'b1, 1'b1, m[31:0], 1'b0, exp_cnt};
      apply(t, $sformatf("wrap%0d_w0", k));
      t = '{1'b0, 1'b0, 96'h0, 1'b1, 1'b1, 1'b1, m[63:32], 1'b0, exp_cnt};
      apply(t, $sformatf("wrap%0d_w1", k));
      t = '{1'b0, 1'b0, 96'h0, 1'b1, 1'b1, 1'b1, m[95:64], 1'b1, exp_cnt};
      apply(t, $sformatf("wrap%0d_w2", k));
      exp_cnt = exp_cnt + 16'd1;
    end
    t = '{1'b0, 1'b0, 96'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, exp_cnt};
    apply(t, "wrap_done");
    check("wrap_small_zero", 96'(s_count), 96'(0));

    check("violation_count", 96'(viol_seen), 96'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
